executor_movimento: RTL
=======================

Name: executor_movimento

Overview:
- Consumes the registered 3-bit movement command `acao` (parado/N/O/L/S) and executes it on the robot's grid position.
- Each accepted command occupies STEP_CYCLES clock cycles of motion, then updates the (pos_x, pos_y) coordinate and counts the completed step.
- Commands that would leave the grid are refused and flagged as a collision.
- Sits downstream of the movement-command generator, on the same clock.

Parameters:
- GRID_W, 8: grid width in cells; legal x is 0..GRID_W-1.
- GRID_H, 8: grid height in cells; legal y is 0..GRID_H-1.
- COORD_W, 3: width of pos_x/pos_y; must satisfy 2^COORD_W >= max(GRID_W, GRID_H).
- STEP_CYCLES, 4: cycles a move stays in progress; must be >= 1.
- X0, 0: reset x coordinate.
- Y0, 0: reset y coordinate.

Ports:
- c3  input  1  system clock; rising edge.
- reset  input  1  asynchronous, active-low reset.
- acao  input  [0:2]  movement command: 000 parado, 001 N (y+1), 010 O (x-1), 011 L (x+1), 100 S (y-1); codes 101..111 are invalid.
- pos_x  output  COORD_W  current x coordinate (registered).
- pos_y  output  COORD_W  current y coordinate (registered).
- ocupado  output  1  high while a move is in progress.
- concluido  output  1  one-cycle pulse when a move completes.
- colisao  output  1  high the cycle after each refused (out-of-grid) request.
- passos  output  8  count of completed moves; wraps 255 -> 0.

Behaviour:
- Reset (reset=0, asynchronous): state OCIOSO, pos_x=X0, pos_y=Y0, ocupado=0, concluido=0, colisao=0, passos=0, step counter=0. Any move in progress is aborted with no position update and no concluido.
- FSM states: OCIOSO, MOVENDO. All outputs are registered.
- OCIOSO, per rising edge of c3:
  - acao = 000 or 101..111: stay in OCIOSO; colisao<=0, concluido<=0.
  - Valid direction whose target cell is outside the grid (N at y=GRID_H-1, S at y=0, L at x=GRID_W-1, O at x=0): stay in OCIOSO; colisao<=1; position and passos unchanged.
  - Valid, in-grid direction: latch the direction, counter<=STEP_CYCLES-1, state<=MOVENDO, ocupado<=1, colisao<=0.
- MOVENDO, per rising edge of c3:
  - acao is ignored; changes during a move have no effect.
  - If counter != 0: counter decrements.
  - If counter == 0: apply the latched direction to pos_x/pos_y (±1), passos<=passos+1 (modulo 256), concluido<=1, ocupado<=0, state<=OCIOSO.
- Timing: a command is accepted at edge k. ocupado is high for cycles k+1 .. k+STEP_CYCLES. The new position and concluido appear after edge k+STEP_CYCLES. concluido drops after the next edge.
- Earliest next acceptance is edge k+STEP_CYCLES+1, so a held command repeats every STEP_CYCLES+1 cycles.
- A held command that is blocked keeps colisao high every cycle until acao changes.
- colisao and concluido are never high in the same cycle. ocupado and concluido are never high in the same cycle.
- Boundary check uses the latched pre-move position. Arithmetic never wraps the coordinates.

Test Plan:
- Reset release at (X0,Y0)=(0,0), acao=011 for one cycle, STEP_CYCLES=4 -> ocupado=1 for 4 cycles; then pos_x=1, pos_y=0, concluido=1 for exactly one cycle, passos=1.
- From (0,0), acao=100 (S) or 010 (O) -> colisao=1 the next cycle, ocupado stays 0, position (0,0), passos=0.
- acao=001 held continuously from (0,0) -> pos_y steps 1..7, one step every 5 cycles; after y=7, colisao stays high, pos_y stays 7, passos=7.
- acao=001 accepted, then acao=100 two cycles later -> the move completes as N, pos_y=1; the S request is not accepted until OCIOSO is re-entered.
- reset pulsed low at the 2nd MOVENDO cycle -> pos=(0,0), ocupado=0, passos=0 immediately; after release with acao=000, no concluido appears.
- acao=101, 110, 111 each held for 10 cycles -> no change to position, ocupado, colisao or passos.

Source files
------------

// File: rtl/executor_movimento.sv
// Grid-motion executor: accepts one movement command at a time, holds it for
// STEP_CYCLES cycles, then commits the new (x, y) position and counts the step.
module executor_movimento #(
  parameter int GRID_W      = 8,
  parameter int GRID_H      = 8,
  parameter int COORD_W     = 3,
  parameter int STEP_CYCLES = 4,
  parameter int X0          = 0,
  parameter int Y0          = 0
) (
  input  logic               c3,
  input  logic               reset,
  input  logic [0:2]         acao,
  output logic [COORD_W-1:0] pos_x,
  output logic [COORD_W-1:0] pos_y,
  output logic               ocupado,
  output logic               concluido,
  output logic               colisao,
  output logic [7:0]         passos
);

  localparam int CNT_W = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [COORD_W-1:0] X_MAX   = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX   = COORD_W'(GRID_H - 1);
  localparam logic [CNT_W-1:0]   CNT_TOP = CNT_W'(STEP_CYCLES - 1);

  localparam logic [2:0] CMD_N = 3'b001;
  localparam logic [2:0] CMD_O = 3'b010;
  localparam logic [2:0] CMD_L = 3'b011;
  localparam logic [2:0] CMD_S = 3'b100;

  typedef enum logic {OCIOSO, MOVENDO} state_t;

  state_t               state_q, state_d;
  logic [2:0]           dir_q, dir_d;
  logic [CNT_W-1:0]     counter_q, counter_d;
  logic [COORD_W-1:0]   pos_x_q, pos_x_d;
  logic [COORD_W-1:0]   pos_y_q, pos_y_d;
  logic                 ocupado_q, ocupado_d;
  logic                 concluido_q, concluido_d;
  logic                 colisao_q, colisao_d;
  logic [7:0]           passos_q, passos_d;

  logic [2:0] cmd;
  logic       cmd_valid;
  logic       cmd_blocked;

  // Re-pack so codes compare as plain 3-bit values regardless of [0:2] order.
  assign cmd = {acao[0], acao[1], acao[2]};

  always_comb begin
    cmd_valid   = 1'b0;
    cmd_blocked = 1'b0;
    case (cmd)
      CMD_N: begin cmd_valid = 1'b1; cmd_blocked = (pos_y_q == Y_MAX); end
      CMD_O: begin cmd_valid = 1'b1; cmd_blocked = (pos_x_q == '0);    end
      CMD_L: begin cmd_valid = 1'b1; cmd_blocked = (pos_x_q == X_MAX); end
      CMD_S: begin cmd_valid = 1'b1; cmd_blocked = (pos_y_q == '0);    end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    dir_d       = dir_q;
    counter_d   = counter_q;
    pos_x_d     = pos_x_q;
    pos_y_d     = pos_y_q;
    ocupado_d   = ocupado_q;
    concluido_d = 1'b0;
    colisao_d   = 1'b0;
    passos_d    = passos_q;

    case (state_q)
      OCIOSO: begin
        if (cmd_valid && cmd_blocked) begin
          colisao_d = 1'b1;
        end else if (cmd_valid) begin
          dir_d     = cmd;
          counter_d = CNT_TOP;
          ocupado_d = 1'b1;
          state_d   = MOVENDO;
        end
      end
      MOVENDO: begin
        if (counter_q != '0) begin
          counter_d = counter_q - 1'b1;
        end else begin
          case (dir_q)
            CMD_N:   pos_y_d = pos_y_q + 1'b1;
            CMD_O:   pos_x_d = pos_x_q - 1'b1;
            CMD_L:   pos_x_d = pos_x_q + 1'b1;
            CMD_S:   pos_y_d = pos_y_q - 1'b1;
            default: ;
          endcase
          passos_d    = passos_q + 8'd1;
          concluido_d = 1'b1;
          ocupado_d   = 1'b0;
          state_d     = OCIOSO;
        end
      end
      default: state_d = OCIOSO;
    endcase
  end

  always_ff @(posedge c3 or negedge reset) begin
    if (!reset) begin
      state_q     <= OCIOSO;
      dir_q       <= '0;
      counter_q   <= '0;
      pos_x_q     <= COORD_W'(X0);
      pos_y_q     <= COORD_W'(Y0);
      ocupado_q   <= 1'b0;
      concluido_q <= 1'b0;
      colisao_q   <= 1'b0;
      passos_q    <= '0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      counter_q   <= counter_d;
      pos_x_q     <= pos_x_d;
      pos_y_q     <= pos_y_d;
      ocupado_q   <= ocupado_d;
      concluido_q <= concluido_d;
      colisao_q   <= colisao_d;
      passos_q    <= passos_d;
    end
  end

  assign pos_x     = pos_x_q;
  assign pos_y     = pos_y_q;
  assign ocupado   = ocupado_q;
  assign concluido = concluido_q;
  assign colisao   = colisao_q;
  assign passos    = passos_q;

endmodule
